// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver/transmitter FSM states and link defaults.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int   DEFAULT_CYCLES_PER_SYMBOL = 125_000_000 / 115_200;
  localparam logic IDLE_LEVEL                = 1'b1;

endpackage

// File: rtl/uart_receiver_if.sv
// Receiver-to-consumer word handshake plus the error pulses. The receiver drives
// the master side, the consumer the slave side.
//
// Handshake contract:
//   - data_valid=1 means data_out holds a word that has not been taken yet.
//   - The word is taken on a rising clk edge where data_valid && data_ready.
//   - data_out does not change while data_valid=1 and the word is untaken.
//   - data_ready while data_valid=0 has no effect.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 data_valid;
  logic                 data_ready;
  logic                 frame_error;
  logic                 overrun;

  modport master (
    output data_out,
    output data_valid,
    output frame_error,
    output overrun,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  overrun,
    output data_ready
  );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input pin. RESET_VALUE should be
// the idle level of the pin.
module uart_sync #(
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_i,
  output logic sync_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RESET_VALUE;
      sync_q <= RESET_VALUE;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/uart_receiver.sv
// UART receiver: recovers start / DATA_BITS (LSB first) / STOP_BITS frames from an
// asynchronous serial line and offers each word on a valid/ready handshake.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CYCLES_PER_SYMBOL = DEFAULT_CYCLES_PER_SYMBOL,
  parameter int DATA_BITS         = 8,
  parameter int STOP_BITS         = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            signal_in,
  uart_receiver_if.master rx_if,
  output uart_state_e     state_o
);

  if (CYCLES_PER_SYMBOL < 4) begin : g_bad_cps
    $error("uart_receiver: CYCLES_PER_SYMBOL must be >= 4");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_receiver: DATA_BITS must be in 5..9");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_receiver: STOP_BITS must be 1 or 2");
  end

  localparam int CW = $clog2(CYCLES_PER_SYMBOL + 1);
  localparam int BW = $clog2(DATA_BITS + STOP_BITS);

  localparam logic [CW-1:0] HALF_C      = CW'(CYCLES_PER_SYMBOL / 2);
  localparam logic [CW-1:0] SYM_LAST_C  = CW'(CYCLES_PER_SYMBOL - 1);
  localparam logic [BW-1:0] DATA_LAST_C = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST_C = BW'(STOP_BITS - 1);

  logic rx_s;

  uart_sync #(.RESET_VALUE(IDLE_LEVEL)) u_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .async_i(signal_in),
    .sync_o (rx_s)
  );

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cyc_q, cyc_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic [1:0]           arm_q;
  logic                 done;

  // rx_s still carries the synchronizer's reset value for two cycles after
  // release; arm_q keeps WAIT_IDLE from trusting it until real line data arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= WAIT_IDLE;
      cyc_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
      arm_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
      arm_q   <= {arm_q[0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    ferr_d  = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      WAIT_IDLE: begin
        cyc_d = '0;
        bit_d = '0;
        if (arm_q[1] && rx_s == IDLE_LEVEL) state_d = IDLE;
      end
      IDLE: begin
        if (rx_s != IDLE_LEVEL) begin
          state_d = START;
          cyc_d   = CW'(1);
        end
      end
      START: begin
        if (cyc_q == HALF_C) begin
          if (rx_s == IDLE_LEVEL) begin
            state_d = IDLE;
          end else begin
            state_d = DATA;
            cyc_d   = '0;
            bit_d   = '0;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      DATA: begin
        if (cyc_q == SYM_LAST_C) begin
          cyc_d   = '0;
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == DATA_LAST_C) begin
            state_d = STOP;
            bit_d   = '0;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      STOP: begin
        if (cyc_q == SYM_LAST_C) begin
          cyc_d = '0;
          if (rx_s != IDLE_LEVEL) begin
            ferr_d  = 1'b1;
            state_d = WAIT_IDLE;
          end else if (bit_q == STOP_LAST_C) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + BW'(1);
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = WAIT_IDLE;
    endcase
  end

  // A completing frame may load in the same cycle the consumer takes the old word.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (valid_q && rx_if.data_ready) valid_d = 1'b0;
    if (done) begin
      if (!valid_q || rx_if.data_ready) begin
        data_d  = shift_q;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  assign rx_if.data_out    = data_q;
  assign rx_if.data_valid  = valid_q;
  assign rx_if.frame_error = ferr_q;
  assign rx_if.overrun     = ovr_q;
  assign state_o           = state_q;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver: an 8N1 instance for the functional cases and
// an 8N2 instance for a back-to-back sweep of every byte value.
module tb_uart_receiver;
  import uart_pkg::*;

  localparam int CPS = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  int   cyc_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  logic        sin1, sin2;
  uart_state_e st1, st2;

  uart_receiver_if #(.DATA_BITS(8)) rx_if ();
  uart_receiver_if #(.DATA_BITS(8)) rx_if2 ();

  uart_receiver #(.CYCLES_PER_SYMBOL(CPS), .DATA_BITS(8), .STOP_BITS(1)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .signal_in(sin1),
    .rx_if    (rx_if),
    .state_o  (st1)
  );

  uart_receiver #(.CYCLES_PER_SYMBOL(CPS), .DATA_BITS(8), .STOP_BITS(2)) u_dut2 (
    .clk      (clk),
    .rst_n    (rst_n),
    .signal_in(sin2),
    .rx_if    (rx_if2),
    .state_o  (st2)
  );

  // ---------------- monitors ----------------
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] got2_q[$];
  int   fe_cnt = 0, ov_cnt = 0, fall_cnt = 0, rise_cyc = -1;
  int   fe2_cnt = 0, ov2_cnt = 0;
  logic dv_prev = 1'b0;

  always @(negedge clk) begin
    if (rx_if.data_valid === 1'b1 && !dv_prev) rise_cyc = cyc_cnt;
    if (rx_if.data_valid === 1'b0 && dv_prev) fall_cnt++;
    dv_prev = (rx_if.data_valid === 1'b1);
    if (rx_if.frame_error === 1'b1) fe_cnt++;
    if (rx_if.overrun === 1'b1) ov_cnt++;
    if (rx_if.data_valid === 1'b1 && rx_if.data_ready === 1'b1) got_q.push_back(rx_if.data_out);
    if (rx_if2.frame_error === 1'b1) fe2_cnt++;
    if (rx_if2.overrun === 1'b1) ov2_cnt++;
    if (rx_if2.data_valid === 1'b1 && rx_if2.data_ready === 1'b1) got2_q.push_back(rx_if2.data_out);
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit to2, input logic v);
    if (to2) sin2 = v;
    else sin1 = v;
  endtask

  task automatic send_frame(input bit to2, input logic [7:0] b, input logic stop_v, input int nstop);
    drive(to2, 1'b0);
    tick(CPS);
    for (int i = 0; i < 8; i++) begin
      drive(to2, b[i]);
      tick(CPS);
    end
    for (int s = 0; s < nstop; s++) begin
      drive(to2, stop_v);
      tick(CPS);
    end
  endtask

  task automatic accept_word(input logic [7:0] expected);
    exp_q.push_back(expected);
    rx_if.data_ready = 1'b1;
    tick(1);
    rx_if.data_ready = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t0, fe0, ov0, fall0;
    logic [7:0] v96;
    rst_n             = 1'b1;
    sin1              = 1'b1;
    sin2              = 1'b1;
    rx_if.data_ready  = 1'b0;
    rx_if2.data_ready = 1'b1;
    #1 rst_n = 1'b0;
    tick(3);
    chk("rst_data_out", rx_if.data_out, 8'h00);
    chk("rst_valid", rx_if.data_valid, 1'b0);
    chk("rst_frame_error", rx_if.frame_error, 1'b0);
    chk("rst_overrun", rx_if.overrun, 1'b0);
    chk("rst_state", st1, WAIT_IDLE);
    rst_n = 1'b1;
    tick(6);
    chk("armed_state", st1, IDLE);

    // 0x55, latency and single-cycle accept
    t0 = cyc_cnt;
    send_frame(1'b0, 8'h55, 1'b1, 1);
    chk("lat_rise_cycle", rise_cyc - t0, 79);
    chk("d55_data", rx_if.data_out, 8'h55);
    chk("d55_valid", rx_if.data_valid, 1'b1);
    tick(3);
    chk("d55_held", rx_if.data_out, 8'h55);
    accept_word(8'h55);
    chk("d55_valid_drop", rx_if.data_valid, 1'b0);

    // 3-cycle glitch, then 0xC3
    fe0 = fe_cnt;
    drive(1'b0, 1'b0);
    tick(3);
    drive(1'b0, 1'b1);
    tick(20);
    chk("glitch_valid", rx_if.data_valid, 1'b0);
    chk("glitch_ferr", fe_cnt - fe0, 0);
    chk("glitch_state", st1, IDLE);
    send_frame(1'b0, 8'hC3, 1'b1, 1);
    chk("dC3_data", rx_if.data_out, 8'hC3);
    accept_word(8'hC3);

    // 0xA3 with low stop bit, line low 40 cycles total
    fe0 = fe_cnt;
    ov0 = ov_cnt;
    send_frame(1'b0, 8'hA3, 1'b0, 1);
    tick(32);
    chk("break_state", st1, WAIT_IDLE);
    drive(1'b0, 1'b1);
    tick(16);
    chk("ferr_pulses", fe_cnt - fe0, 1);
    chk("ferr_valid", rx_if.data_valid, 1'b0);
    chk("ferr_no_ovr", ov_cnt - ov0, 0);
    send_frame(1'b0, 8'h3C, 1'b1, 1);
    chk("d3C_data", rx_if.data_out, 8'h3C);
    chk("d3C_valid", rx_if.data_valid, 1'b1);
    accept_word(8'h3C);

    // back-to-back with no consumer: second word dropped as overrun
    ov0 = ov_cnt;
    fe0 = fe_cnt;
    send_frame(1'b0, 8'h01, 1'b1, 1);
    send_frame(1'b0, 8'h02, 1'b1, 1);
    tick(2);
    chk("ovr_data_kept", rx_if.data_out, 8'h01);
    chk("ovr_valid", rx_if.data_valid, 1'b1);
    chk("ovr_pulses", ov_cnt - ov0, 1);
    chk("ovr_no_ferr", fe_cnt - fe0, 0);
    accept_word(8'h01);
    chk("ovr_valid_drop", rx_if.data_valid, 1'b0);

    // back-to-back with accept in the completion cycle: no overrun, valid stays
    ov0 = ov_cnt;
    send_frame(1'b0, 8'h01, 1'b1, 1);
    fall0 = fall_cnt;
    exp_q.push_back(8'h01);
    fork
      send_frame(1'b0, 8'h02, 1'b1, 1);
      begin
        tick(78);
        rx_if.data_ready = 1'b1;
        tick(1);
        rx_if.data_ready = 1'b0;
      end
    join
    tick(2);
    chk("swap_data", rx_if.data_out, 8'h02);
    chk("swap_valid", rx_if.data_valid, 1'b1);
    chk("swap_no_fall", fall_cnt - fall0, 0);
    chk("swap_no_ovr", ov_cnt - ov0, 0);

    // reset during data bit 3 of 0x96 while 0x02 is still pending
    v96 = 8'h96;
    fe0 = fe_cnt;
    drive(1'b0, 1'b0);
    tick(CPS);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, v96[i]);
      tick(CPS);
    end
    drive(1'b0, v96[3]);
    tick(4);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rx_if.data_valid, 1'b0);
    chk("mid_rst_data", rx_if.data_out, 8'h00);
    chk("mid_rst_ferr", rx_if.frame_error, 1'b0);
    chk("mid_rst_ovr", rx_if.overrun, 1'b0);
    tick(3);
    drive(1'b0, 1'b0);
    rst_n = 1'b1;
    tick(20);
    chk("low_after_rst_state", st1, WAIT_IDLE);
    drive(1'b0, 1'b1);
    tick(20);
    fe0 = fe_cnt - fe0;
    chk("no_spurious_valid", rx_if.data_valid, 1'b0);
    chk("no_spurious_ferr", fe0, 0);
    send_frame(1'b0, 8'hFF, 1'b1, 1);
    chk("dFF_data", rx_if.data_out, 8'hFF);
    chk("dFF_valid", rx_if.data_valid, 1'b1);
    accept_word(8'hFF);

    chk("acc_count", got_q.size(), exp_q.size());
    while (got_q.size() > 0 && exp_q.size() > 0)
      chk("acc_word", got_q.pop_front(), exp_q.pop_front());

    // 8N2 sweep of every byte back-to-back
    for (int v = 0; v < 256; v++) send_frame(1'b1, v[7:0], 1'b1, 2);
    tick(4);
    chk("sweep_count", got2_q.size(), 256);
    chk("sweep_ferr", fe2_cnt, 0);
    chk("sweep_ovr", ov2_cnt, 0);
    for (int v = 0; v < 256 && got2_q.size() > 0; v++)
      chk("sweep_word", got2_q.pop_front(), v[7:0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
